// File: rtl/peridot_avm_arbiter.sv
// rtl/peridot_avm_arbiter.sv - two-port Avalon-MM arbiter sharing one pipelined master
// Grant is held per burst and moves only once the owner's outstanding reads have returned.
module peridot_avm_arbiter #(
  parameter int    ADDR_WIDTH     = 32,
  parameter string PRIORITY       = "ROUNDROBIN",
  parameter int    MAX_PENDING    = 4,
  parameter int    HOLD_TRANSFERS = 16
) (
  input  logic                  csi_clk,
  input  logic                  rsi_reset_n,
  input  logic [ADDR_WIDTH-1:0] avs_s0_address,
  input  logic                  avs_s0_read,
  input  logic                  avs_s0_write,
  input  logic [3:0]            avs_s0_byteenable,
  input  logic [31:0]           avs_s0_writedata,
  output logic [31:0]           avs_s0_readdata,
  output logic                  avs_s0_waitrequest,
  output logic                  avs_s0_readdatavalid,
  input  logic [ADDR_WIDTH-1:0] avs_s1_address,
  input  logic                  avs_s1_read,
  input  logic                  avs_s1_write,
  input  logic [3:0]            avs_s1_byteenable,
  input  logic [31:0]           avs_s1_writedata,
  output logic [31:0]           avs_s1_readdata,
  output logic                  avs_s1_waitrequest,
  output logic                  avs_s1_readdatavalid,
  output logic [ADDR_WIDTH-1:0] avm_m1_address,
  output logic                  avm_m1_read,
  output logic                  avm_m1_write,
  output logic [3:0]            avm_m1_byteenable,
  output logic [31:0]           avm_m1_writedata,
  input  logic [31:0]           avm_m1_readdata,
  input  logic                  avm_m1_waitrequest,
  input  logic                  avm_m1_readdatavalid
);

  typedef enum logic [1:0] {IDLE = 2'd0, OWN0 = 2'd1, OWN1 = 2'd2, DRAIN = 2'd3} state_e;

  localparam bit         FIXED_PRIO = (PRIORITY == "FIXED");
  localparam logic [3:0] MAX_PEND   = 4'(MAX_PENDING);
  localparam logic [7:0] HOLD_MAX   = 8'(HOLD_TRANSFERS);

  state_e     state_q, state_d;
  logic [3:0] pending_q, pending_d;
  logic [7:0] hold_q, hold_d;
  logic       last_q, last_d;

  logic req0, req1, owned, owner, own_read, own_write, other_req;
  logic pend_full, m_read, m_write, accept, rd_accept, rdv_live;
  logic own_wait, hold_hit, release_own, pick1;

  assign req0      = avs_s0_read | avs_s0_write;
  assign req1      = avs_s1_read | avs_s1_write;
  assign owned     = (state_q == OWN0) || (state_q == OWN1);
  assign owner     = (state_q == OWN1);
  assign own_read  = owner ? avs_s1_read  : avs_s0_read;
  assign own_write = owner ? avs_s1_write : avs_s0_write;
  assign other_req = owner ? req0 : req1;
  assign pend_full = (pending_q == MAX_PEND);

  // Reads stop at the pending cap; writes are never throttled by it.
  assign m_read    = owned & own_read & (pending_q < MAX_PEND);
  assign m_write   = owned & own_write;
  assign accept    = (m_read | m_write) & ~avm_m1_waitrequest;
  assign rd_accept = m_read & ~avm_m1_waitrequest;
  assign rdv_live  = avm_m1_readdatavalid & (pending_q != 4'd0);
  assign own_wait  = avm_m1_waitrequest | (own_read & pend_full);
  assign hold_hit  = ({1'b0, hold_q} + 9'd1) >= {1'b0, HOLD_MAX};
  assign release_own = ~(own_read | own_write) | (accept & hold_hit & other_req);

  assign avm_m1_address       = owner ? avs_s1_address    : avs_s0_address;
  assign avm_m1_byteenable    = owner ? avs_s1_byteenable : avs_s0_byteenable;
  assign avm_m1_writedata     = owner ? avs_s1_writedata  : avs_s0_writedata;
  assign avm_m1_read          = m_read;
  assign avm_m1_write         = m_write;
  assign avs_s0_waitrequest   = (state_q == OWN0) ? own_wait : 1'b1;
  assign avs_s1_waitrequest   = (state_q == OWN1) ? own_wait : 1'b1;
  assign avs_s0_readdata      = avm_m1_readdata;
  assign avs_s1_readdata      = avm_m1_readdata;
  assign avs_s0_readdatavalid = rdv_live & ~last_q;
  assign avs_s1_readdatavalid = rdv_live & last_q;

  always_comb begin
    pending_d = pending_q;
    if (rd_accept && !rdv_live) begin
      pending_d = pending_q + 4'd1;
    end else if (!rd_accept && rdv_live) begin
      pending_d = pending_q - 4'd1;
    end
  end

  always_comb begin
    state_d = state_q;
    hold_d  = hold_q;
    last_d  = last_q;
    pick1   = 1'b0;
    case (state_q)
      IDLE: begin
        if (req0 || req1) begin
          if (req0 && req1) begin
            pick1 = FIXED_PRIO ? 1'b0 : ~last_q;
          end else begin
            pick1 = req1;
          end
          state_d = pick1 ? OWN1 : OWN0;
          hold_d  = 8'd0;
          last_d  = pick1;
        end
      end
      OWN0, OWN1: begin
        if (accept && (hold_q != HOLD_MAX)) begin
          hold_d = hold_q + 8'd1;
        end
        if (release_own) begin
          state_d = (pending_d == 4'd0) ? IDLE : DRAIN;
        end
      end
      DRAIN: begin
        if (pending_d == 4'd0) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // last resets to s1 so that s0 wins the first round-robin tie.
  always_ff @(posedge csi_clk or negedge rsi_reset_n) begin
    if (!rsi_reset_n) begin
      state_q   <= IDLE;
      pending_q <= 4'd0;
      hold_q    <= 8'd0;
      last_q    <= 1'b1;
    end else begin
      state_q   <= state_d;
      pending_q <= pending_d;
      hold_q    <= hold_d;
      last_q    <= last_d;
    end
  end

endmodule

// File: doc/peridot_avm_arbiter.md
Name: peridot_avm_arbiter

Overview:
- Two-requester arbiter that shares a single Avalon-MM pipelined master port between the host-bridge packet master (s0) and a second master (s1), such as a debug or DMA engine.
- Grant is held per burst of transfers. A grant switch happens only after all outstanding reads from the current owner have returned, so read data is always routed to the requester that issued it.
- Sits between the requesting masters and the system interconnect in the avmclock domain.

Parameters:
- ADDR_WIDTH, 32, address width of all ports.
- PRIORITY, "ROUNDROBIN", "ROUNDROBIN" or "FIXED" (in FIXED, s0 always wins when both request).
- MAX_PENDING, 4, maximum outstanding reads (1..15).
- HOLD_TRANSFERS, 16, accepted commands after which the owner is preempted if the other port is requesting (1..255).

Ports:
- csi_clk  in  1  clock, all logic on rising edge.
- rsi_reset_n  in  1  reset, asynchronous, active-low.
- avs_s0_address  in  ADDR_WIDTH  s0 address.
- avs_s0_read  in  1  s0 read request.
- avs_s0_write  in  1  s0 write request.
- avs_s0_byteenable  in  4  s0 byte enables.
- avs_s0_writedata  in  32  s0 write data.
- avs_s0_readdata  out  32  s0 read data.
- avs_s0_waitrequest  out  1  s0 stall.
- avs_s0_readdatavalid  out  1  s0 read data valid.
- avs_s1_*  (same eight signals as s0)  s1 port.
- avm_m1_address  out  ADDR_WIDTH  shared master address.
- avm_m1_read  out  1  shared master read.
- avm_m1_write  out  1  shared master write.
- avm_m1_byteenable  out  4  shared master byte enables.
- avm_m1_writedata  out  32  shared master write data.
- avm_m1_readdata  in  32  shared master read data.
- avm_m1_waitrequest  in  1  shared master stall.
- avm_m1_readdatavalid  in  1  shared master read data valid.

Behaviour:
- Reset (rsi_reset_n=0, async):
  - state=IDLE, pending=0, hold=0, last=s1 (so s0 wins the first round-robin tie).
  - avm_m1_read=0, avm_m1_write=0.
  - both avs_sX_waitrequest=1, both avs_sX_readdatavalid=0.
  - Reset mid-transaction discards pending count and grant; late readdatavalid after reset is ignored (pending=0 means no owner).
- Definitions:
  - reqX = avs_sX_read | avs_sX_write.
  - accept = (avm_m1_read | avm_m1_write) & ~avm_m1_waitrequest.
- States: IDLE, OWN0, OWN1, DRAIN (2-bit registered grant).
- IDLE:
  - Master outputs read/write=0; both waitrequest=1.
  - If req0|req1, choose winner and go to OWNx next cycle. Request-to-first-presentation latency is 1 cycle.
  - ROUNDROBIN: if both request, the port that is not `last` wins. FIXED: s0 wins.
  - On entering OWNx: hold=0, last=x.
- OWNx (combinational pass-through from owner sX):
  - address, byteenable, writedata, write go straight to the master port.
  - avm_m1_read = avs_sX_read & (pending<MAX_PENDING).
  - avs_sX_waitrequest = avm_m1_waitrequest | (avs_sX_read & pending==MAX_PENDING).
  - Non-owner waitrequest=1.
- Pending counter:
  - +1 on accepted read; -1 on avm_m1_readdatavalid; both in the same cycle → unchanged.
  - Width is 4 bits; it never overflows because reads are gated at MAX_PENDING.
- Hold counter:
  - +1 per accept, saturating at HOLD_TRANSFERS.
- Leaving OWNx (evaluated each cycle):
  - release = ~reqX, or (accept & hold+1>=HOLD_TRANSFERS & other port requesting).
  - A release is never taken while the owner holds an unaccepted command.
  - On release: if pending==0 (after this cycle's update) → IDLE, else → DRAIN.
- DRAIN:
  - Master read/write=0; both waitrequest=1.
  - Returning data is still routed to `last`.
  - Go to IDLE on the cycle pending reaches 0.
- Read data routing:
  - avs_sX_readdata = avm_m1_readdata for both ports.
  - avs_sX_readdatavalid = avm_m1_readdatavalid & (last==X) & (pending!=0).
  - readdatavalid while pending==0 is dropped, and pending does not underflow.
- Writes are never gated by the pending count.
- Simultaneous first requests in IDLE resolve per PRIORITY. After a release, the next IDLE cycle re-arbitrates, so round-robin alternates under continuous contention.

Test Plan:
- Single s0 read to 0x1000, slave waitrequest=0, readdatavalid 2 cycles later, data 0xCAFEF00D:
  - avm_m1_read is seen 1 cycle after avs_s0_read.
  - avs_s0_readdatavalid=1 with 0xCAFEF00D.
  - s1 waitrequest stays 1 throughout.
- Both ports continuously write, HOLD_TRANSFERS=4, ROUNDROBIN:
  - Master sees exactly 4 s0 writes, 1 IDLE cycle, then 4 s1 writes, repeating.
  - No write is lost or duplicated (all 32 data words checked).
- s0 issues 6 pipelined reads, MAX_PENDING=4, slave delays readdatavalid by 10 cycles:
  - avm_m1_read deasserts after the 4th accept and avs_s0_waitrequest=1.
  - Reads resume when the first data returns; all 6 data words arrive in order on s0 only.
- s0 has 3 reads outstanding when s1 requests and s0 deasserts:
  - State goes to DRAIN; s1 sees no master activity until all 3 s0 readdatavalid pulses arrive.
  - s1's first read is presented 2 cycles after the last return (DRAIN→IDLE→OWN1).
- PRIORITY=FIXED, both request continuously, HOLD_TRANSFERS=2:
  - s0 regains the grant after every release; s1 is never granted while s0 requests.
- Assert rsi_reset_n=0 asynchronously with 2 reads pending, then release it:
  - All outputs return to reset values immediately, without waiting for a clock edge.
  - Stray readdatavalid after reset produces no avs_sX_readdatavalid.
  - The next s1 request is granted normally.
